// File: rtl/stack_binop_pkg.sv
// Shared codes for the operand stack and the binary-operator sequencer:
// stack ops, stack status, operator opcodes and completion error codes.
package stack_binop_pkg;

  localparam logic [1:0] STK_NONE    = 2'd0;
  localparam logic [1:0] STK_PUSH    = 2'd1;
  localparam logic [1:0] STK_POP     = 2'd2;
  localparam logic [1:0] STK_REPLACE = 2'd3;

  localparam logic [1:0] STAT_NONE      = 2'd0;
  localparam logic [1:0] STAT_EMPTY     = 2'd1;
  localparam logic [1:0] STAT_UNDERFLOW = 2'd2;
  localparam logic [1:0] STAT_OVERFLOW  = 2'd3;

  localparam logic [3:0] OPC_ADD   = 4'd0;
  localparam logic [3:0] OPC_SUB   = 4'd1;
  localparam logic [3:0] OPC_AND   = 4'd2;
  localparam logic [3:0] OPC_OR    = 4'd3;
  localparam logic [3:0] OPC_XOR   = 4'd4;
  localparam logic [3:0] OPC_SHL   = 4'd5;
  localparam logic [3:0] OPC_SHR_U = 4'd6;
  localparam logic [3:0] OPC_EQ    = 4'd7;
  localparam logic [3:0] OPC_LT_U  = 4'd8;
  localparam logic [3:0] OPC_LT_S  = 4'd9;

  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_BADOP     = 2'd2;

  // OVERFLOW still means the stack holds elements.
  function automatic logic stack_is_empty(input logic [1:0] status);
    return (status == STAT_EMPTY) || (status == STAT_UNDERFLOW);
  endfunction

endpackage

// File: rtl/stack_binop_if.sv
// Decoder request/completion signals plus the operand-stack control bundle.
interface stack_binop_if #(
  parameter int WIDTH = 32
) ();
  // Request handshake: a request is accepted on a rising edge where
  // req_valid && req_ready; req_opcode only needs to be valid in that cycle.
  // Completion is a one-cycle done pulse, error valid while done is high.
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic             done;
  logic [1:0]       error;
  logic [1:0]       stack_op;
  logic [WIDTH-1:0] stack_data;
  logic [WIDTH-1:0] stack_tos;
  logic [1:0]       stack_status;

  modport slave (
    input  req_valid, req_opcode, stack_tos, stack_status,
    output req_ready, done, error, stack_op, stack_data
  );

  modport master (
    output req_valid, req_opcode, stack_tos, stack_status,
    input  req_ready, done, error, stack_op, stack_data
  );
endinterface

// File: rtl/stack_binop_alu.sv
// Combinational binary-operator datapath: a OP b, flags unknown opcodes.
module binop_alu
  import stack_binop_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             badop
);

  logic [WIDTH-1:0] shamt;

  assign shamt = b % WIDTH'(WIDTH);

  always_comb begin
    result = '0;
    badop  = 1'b0;
    case (opcode)
      OPC_ADD:   result = a + b;
      OPC_SUB:   result = a - b;
      OPC_AND:   result = a & b;
      OPC_OR:    result = a | b;
      OPC_XOR:   result = a ^ b;
      OPC_SHL:   result = a << shamt;
      OPC_SHR_U: result = a >> shamt;
      OPC_EQ:    result = {{(WIDTH-1){1'b0}}, (a == b)};
      OPC_LT_U:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      OPC_LT_S:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:   badop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/stack_binop.sv
// Sequencer that pops b, reads a, and replaces a with (a OP b) on the
// operand stack, reporting completion through a one-cycle done pulse.
module stack_binop
  import stack_binop_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  stack_binop_if.slave   bus,
  output logic [1:0]     dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POP   = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       stack_op_q, stack_op_d;
  logic [WIDTH-1:0] stack_data_q, stack_data_d;
  logic             done_q, done_d;
  logic [1:0]       error_q, error_d;

  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_badop;

  // In IDLE the ALU only decodes the incoming opcode for the BADOP check.
  assign alu_opcode = (state_q == S_IDLE) ? bus.req_opcode : opcode_q;

  binop_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (alu_opcode),
    .a      (bus.stack_tos),
    .b      (b_q),
    .result (alu_result),
    .badop  (alu_badop)
  );

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    b_d          = b_q;
    stack_op_d   = stack_op_q;
    stack_data_d = stack_data_q;
    done_d       = 1'b0;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (alu_badop) begin
            done_d  = 1'b1;
            error_d = ERR_BADOP;
          end else if (stack_is_empty(bus.stack_status)) begin
            done_d  = 1'b1;
            error_d = ERR_UNDERFLOW;
          end else begin
            opcode_d   = bus.req_opcode;
            b_d        = bus.stack_tos;
            stack_op_d = STK_POP;
            state_d    = S_POP;
          end
        end
      end
      S_POP: begin
        stack_op_d = STK_NONE;
        state_d    = S_READ;
      end
      S_READ: begin
        // b is already consumed; a missing a leaves the stack one shorter.
        if (stack_is_empty(bus.stack_status)) begin
          done_d  = 1'b1;
          error_d = ERR_UNDERFLOW;
          state_d = S_IDLE;
        end else begin
          stack_data_d = alu_result;
          stack_op_d   = STK_REPLACE;
          state_d      = S_WRITE;
        end
      end
      default: begin
        stack_op_d = STK_NONE;
        done_d     = 1'b1;
        error_d    = ERR_OK;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      b_q          <= '0;
      stack_op_q   <= STK_NONE;
      stack_data_q <= '0;
      done_q       <= 1'b0;
      error_q      <= ERR_OK;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      b_q          <= b_d;
      stack_op_q   <= stack_op_d;
      stack_data_q <= stack_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.stack_op   = stack_op_q;
  assign bus.stack_data = stack_data_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_stack_binop.sv
// Bench for stack_binop: a small operand-stack model, directed vector table
// and hand-written sequences for timing, errors and mid-operation reset.
module tb_stack_binop;
  import stack_binop_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  stack_binop_if #(.WIDTH(W)) bus ();

  stack_binop #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- operand stack model ----------------
  logic [1:0]   tb_op;
  logic [W-1:0] tb_data;
  logic [1:0]   op_in;
  logic [W-1:0] data_in;
  logic [W-1:0] mem [DEPTH];
  logic [3:0]   cnt;
  logic         unf, ovf;
  int           rep_seen;
  int           push_seen;

  assign op_in   = (tb_op != STK_NONE) ? tb_op : bus.stack_op;
  assign data_in = (tb_op != STK_NONE) ? tb_data : bus.stack_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      unf <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (op_in)
        STK_PUSH: begin
          if (cnt == 4'(DEPTH)) ovf <= 1'b1;
          else begin
            mem[cnt[2:0]] <= data_in;
            cnt <= cnt + 4'd1;
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
        STK_POP: begin
          if (cnt == 4'd0) unf <= 1'b1;
          else begin
            cnt <= cnt - 4'd1;
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
        STK_REPLACE: begin
          if (cnt == 4'd0) unf <= 1'b1;
          else mem[3'(cnt - 4'd1)] <= data_in;
        end
        default: ;
      endcase
    end
  end

  assign bus.stack_tos    = (cnt == 4'd0) ? '0 : mem[3'(cnt - 4'd1)];
  assign bus.stack_status = unf ? STAT_UNDERFLOW :
                            ovf ? STAT_OVERFLOW  :
                            (cnt == 4'd0) ? STAT_EMPTY : STAT_NONE;

  always @(posedge clk) begin
    if (bus.stack_op == STK_REPLACE) rep_seen = rep_seen + 1;
    if (bus.stack_op == STK_PUSH)    push_seen = push_seen + 1;
  end

  // ---------------- scoreboard / checks ----------------
  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stk_push(input logic [W-1:0] v);
    tb_op = STK_PUSH;
    tb_data = v;
    tick();
    tb_op = STK_NONE;
  endtask

  task automatic stk_pop();
    tb_op = STK_POP;
    tick();
    tb_op = STK_NONE;
  endtask

  // Presents one request and returns cycles from accept to done (99 = none).
  task automatic do_req(input logic [3:0] opc, output int lat, output logic [1:0] err);
    bus.req_valid  = 1'b1;
    bus.req_opcode = opc;
    tick();
    bus.req_valid  = 1'b0;
    bus.req_opcode = 4'hF;
    lat = 1;
    while (!bus.done && lat < 12) begin
      tick();
      lat++;
    end
    err = bus.error;
    if (!bus.done) lat = 99;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [3:0]   opc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int lat;
    logic [1:0] err;
    int acc[3];
    int n_acc;
    int rep0;

    vecs[0]  = '{"add_wrap",  OPC_ADD,   32'hFFFF_FFFF, 32'h1,          32'h0};
    vecs[1]  = '{"ltu_max",   OPC_LT_U,  32'hFFFF_FFFF, 32'h1,          32'h0};
    vecs[2]  = '{"lts_neg",   OPC_LT_S,  32'hFFFF_FFFF, 32'h1,          32'h1};
    vecs[3]  = '{"shl_max",   OPC_SHL,   32'hFFFF_FFFF, 32'h1,          32'hFFFF_FFFE};
    vecs[4]  = '{"shru_max",  OPC_SHR_U, 32'hFFFF_FFFF, 32'h1,          32'h7FFF_FFFF};
    vecs[5]  = '{"shl_33",    OPC_SHL,   32'h3,         32'd33,         32'h6};
    vecs[6]  = '{"shru_33",   OPC_SHR_U, 32'h8000_0000, 32'd33,         32'h4000_0000};
    vecs[7]  = '{"sub_pos",   OPC_SUB,   32'd7,         32'd5,          32'd2};
    vecs[8]  = '{"sub_wrap",  OPC_SUB,   32'd5,         32'd7,          32'hFFFF_FFFE};
    vecs[9]  = '{"and",       OPC_AND,   32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000};
    vecs[10] = '{"or",        OPC_OR,    32'hF0F0_F0F0, 32'hFF00_FF00,  32'hFFF0_FFF0};
    vecs[11] = '{"xor",       OPC_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0};
    vecs[12] = '{"eq_true",   OPC_EQ,    32'd5,         32'd5,          32'h1};
    vecs[13] = '{"eq_false",  OPC_EQ,    32'd5,         32'd6,          32'h0};
    vecs[14] = '{"ltu_true",  OPC_LT_U,  32'd1,         32'd2,          32'h1};
    vecs[15] = '{"lts_false", OPC_LT_S,  32'd1,         32'hFFFF_FFFF,  32'h0};

    n_checks = 0;
    n_errors = 0;
    rep_seen = 0;
    push_seen = 0;
    tb_op = STK_NONE;
    tb_data = '0;
    bus.req_valid = 1'b0;
    bus.req_opcode = 4'h0;

    // ---- reset ----
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", W'(bus.req_ready), 32'h1);
    chk("rst_done", W'(bus.done), 32'h0);
    chk("rst_error", W'(bus.error), 32'h0);
    chk("rst_stack_op", W'(bus.stack_op), 32'h0);
    chk("rst_stack_data", bus.stack_data, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // ---- normal op: 7 - 5 with cycle-by-cycle timing ----
    stk_push(32'd7);
    stk_push(32'd5);
    bus.req_valid = 1'b1;
    bus.req_opcode = OPC_SUB;
    tick();
    bus.req_valid = 1'b0;
    bus.req_opcode = 4'hF;
    chk("n_t1_op", W'(bus.stack_op), W'(STK_POP));
    chk("n_t1_ready", W'(bus.req_ready), 32'h0);
    tick();
    chk("n_t2_tos", bus.stack_tos, 32'd7);
    chk("n_t2_op", W'(bus.stack_op), W'(STK_NONE));
    tick();
    chk("n_t3_op", W'(bus.stack_op), W'(STK_REPLACE));
    chk("n_t3_data", bus.stack_data, 32'd2);
    chk("n_t3_done", W'(bus.done), 32'h0);
    tick();
    chk("n_t4_done", W'(bus.done), 32'h1);
    chk("n_t4_error", W'(bus.error), W'(ERR_OK));
    chk("n_t4_tos", bus.stack_tos, 32'd2);
    chk("n_t4_ready", W'(bus.req_ready), 32'h1);
    chk("n_t4_depth", W'(cnt), 32'd1);
    chk("n_t4_data_hold", bus.stack_data, 32'd2);
    tick();
    chk("n_t5_done_pulse", W'(bus.done), 32'h0);
    stk_pop();

    // ---- empty stack ----
    rep0 = rep_seen;
    bus.req_valid = 1'b1;
    bus.req_opcode = OPC_ADD;
    tick();
    bus.req_valid = 1'b0;
    chk("e_t1_done", W'(bus.done), 32'h1);
    chk("e_t1_error", W'(bus.error), W'(ERR_UNDERFLOW));
    chk("e_t1_op", W'(bus.stack_op), W'(STK_NONE));
    chk("e_t1_ready", W'(bus.req_ready), 32'h1);
    tick();
    chk("e_t2_done", W'(bus.done), 32'h0);
    chk("e_t2_op", W'(bus.stack_op), W'(STK_NONE));
    chk("e_depth", W'(cnt), 32'd0);

    // ---- late underflow ----
    stk_push(32'd9);
    bus.req_valid = 1'b1;
    bus.req_opcode = OPC_ADD;
    tick();
    bus.req_valid = 1'b0;
    chk("u_t1_op", W'(bus.stack_op), W'(STK_POP));
    tick();
    chk("u_t2_done", W'(bus.done), 32'h0);
    tick();
    chk("u_t3_done", W'(bus.done), 32'h1);
    chk("u_t3_error", W'(bus.error), W'(ERR_UNDERFLOW));
    chk("u_t3_op", W'(bus.stack_op), W'(STK_NONE));
    chk("u_t3_status", W'(bus.stack_status), W'(STAT_EMPTY));
    chk("u_t3_ready", W'(bus.req_ready), 32'h1);
    tick();
    chk("u_no_replace", W'(rep_seen - rep0), 32'h0);

    // ---- BADOP ----
    stk_push(32'd3);
    stk_push(32'd4);
    bus.req_valid = 1'b1;
    bus.req_opcode = 4'd12;
    tick();
    bus.req_valid = 1'b0;
    chk("b_t1_done", W'(bus.done), 32'h1);
    chk("b_t1_error", W'(bus.error), W'(ERR_BADOP));
    chk("b_t1_op", W'(bus.stack_op), W'(STK_NONE));
    tick();
    chk("b_t2_done", W'(bus.done), 32'h0);
    chk("b_error_hold", W'(bus.error), W'(ERR_BADOP));
    chk("b_tos", bus.stack_tos, 32'd4);
    chk("b_depth", W'(cnt), 32'd2);
    stk_pop();
    stk_pop();

    // ---- opcode sweep table ----
    for (int i = 0; i < 16; i++) begin
      stk_push(vecs[i].a);
      stk_push(vecs[i].b);
      exp_q.push_back(vecs[i].exp);
      do_req(vecs[i].opc, lat, err);
      chk({vecs[i].name, "_lat"}, W'(lat), 32'd4);
      chk({vecs[i].name, "_err"}, W'(err), W'(ERR_OK));
      chk({vecs[i].name, "_res"}, bus.stack_tos, exp_q.pop_front());
      chk({vecs[i].name, "_depth"}, W'(cnt), 32'd1);
      stk_pop();
    end

    // ---- back-to-back: ((4+3)+2)+1 ----
    stk_push(32'd1);
    stk_push(32'd2);
    stk_push(32'd3);
    stk_push(32'd4);
    n_acc = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    bus.req_valid = 1'b1;
    bus.req_opcode = OPC_ADD;
    for (int c = 0; c < 14; c++) begin
      if (bus.req_valid && bus.req_ready && n_acc < 3) begin
        acc[n_acc] = c;
        n_acc++;
      end
      tick();
      if (n_acc == 3) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    chk("bb_accepts", W'(n_acc), 32'd3);
    chk("bb_gap1", W'(acc[1] - acc[0]), 32'd4);
    chk("bb_gap2", W'(acc[2] - acc[1]), 32'd4);
    chk("bb_tos", bus.stack_tos, 32'd10);
    chk("bb_depth", W'(cnt), 32'd1);
    stk_pop();

    // ---- reset in READ ----
    stk_push(32'd2);
    stk_push(32'd3);
    bus.req_valid = 1'b1;
    bus.req_opcode = OPC_ADD;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("r_in_read", W'(dbg_state), 32'd2);
    reset = 1'b1;
    #1;
    chk("r_op", W'(bus.stack_op), W'(STK_NONE));
    chk("r_data", bus.stack_data, 32'h0);
    chk("r_done", W'(bus.done), 32'h0);
    chk("r_error", W'(bus.error), 32'h0);
    chk("r_ready", W'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("r_after_done", W'(bus.done), 32'h0);
    chk("r_after_ready", W'(bus.req_ready), 32'h1);
    stk_push(32'd4);
    stk_push(32'd6);
    do_req(OPC_ADD, lat, err);
    chk("r_add_lat", W'(lat), 32'd4);
    chk("r_add_err", W'(err), W'(ERR_OK));
    chk("r_add_tos", bus.stack_tos, 32'd10);
    chk("r_add_depth", W'(cnt), 32'd1);

    chk("never_push", W'(push_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/stack_binop.md
# stack_binop

Sequencer that executes one WebAssembly-style binary operator against the operand stack. It sits directly upstream of the operand stack: it owns the stack's `op`/`data` inputs and reads back `tos`/`status`. Each accepted request pops operand b, reads operand a, computes `a OP b`, and writes the result over a with REPLACE, for a net stack depth change of −1. Completion and errors are reported to the decoder through a one-cycle `done` pulse.

## Interface

- `WIDTH`, default 32: operand and stack word width in bits; must match the stack's `WIDTH`.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high; shared with the stack.
- `req_valid`, input, 1: decoder presents `req_opcode`.
- `req_ready`, output, 1: high only in IDLE.
- `req_opcode`, input, 4: binary operator code, see Operation.
- `done`, output, 1: one-cycle pulse marking request completion, with or without error.
- `error`, output, 2: result code, valid while `done` is high: 0 = OK, 1 = UNDERFLOW, 2 = BADOP.
- `stack_op`, output, 2: to stack `op`: 0 = none, 1 = push, 2 = pop, 3 = replace. Registered.
- `stack_data`, output, WIDTH: to stack `data`. Registered.
- `stack_tos`, input, WIDTH: from stack `tos`.
- `stack_status`, input, 2: from stack `status`: 0 = none, 1 = empty, 2 = underflow, 3 = overflow.

## Operation

- **Opcodes** (a = deeper operand, b = top of stack):
  - 0 ADD: a+b mod 2^WIDTH.
  - 1 SUB: a−b mod 2^WIDTH.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SHL: a << (b mod WIDTH).
  - 6 SHR_U: logical a >> (b mod WIDTH).
  - 7 EQ: 1 if a==b, else 0.
  - 8 LT_U: unsigned a<b.
  - 9 LT_S: two's-complement a<b.
  - 10–15: BADOP.
- **Comparison results** are zero-extended to WIDTH.
- **Stack empty test:** the stack is empty when `stack_status` is EMPTY or UNDERFLOW. NONE and OVERFLOW both mean non-empty.
- **FSM** (`req_ready` = state==IDLE):
  - IDLE → on `req_valid`:
    - Opcode is BADOP: pulse `done` with `error`=2, stay IDLE, no stack op.
    - Stack empty: pulse `done` with `error`=1, stay IDLE, no stack op.
    - Otherwise: latch opcode, latch b←`stack_tos`, set `stack_op`←POP, go to POP.
  - POP → set `stack_op`←NONE, go to READ. The stack executes the pop on this edge.
  - READ → branch on `stack_status`:
    - EMPTY: a is missing. Pulse `done` with `error`=1, no write, go to IDLE. The stack is left one element shorter (b has been consumed).
    - Otherwise: latch a←`stack_tos`, set `stack_data`←result, `stack_op`←REPLACE, go to WRITE.
  - WRITE → set `stack_op`←NONE, pulse `done` with `error`=0, go to IDLE.
- **Output policy:**
  - PUSH is never issued.
  - `stack_data` holds its last value whenever `stack_op` is NONE.
  - `error` holds its last value between pulses.
- **Reset (any cycle, including mid-operation):**
  - State → IDLE; `stack_op` → NONE; `stack_data` → 0; `done` → 0; `error` → 0; `req_ready` → 1.
  - Any in-flight request is abandoned. The stack is reset by the same signal.

## Timing

- **Request timeline** (request accepted at the edge ending cycle T):
  - T+1: `stack_op`=POP.
  - T+2: `stack_tos` = a.
  - T+3: `stack_op`=REPLACE with result.
  - T+4: `done`=1 with `error`=0; `stack_tos` already equals the result; `req_ready`=1.
- **Throughput:** a back-to-back request can be accepted in T+4, giving one operator per 4 cycles.
- **Early errors:** BADOP or empty-stack rejection raises `done` in T+1.
- **Late underflow:** `done` is raised in T+3.
- `req_opcode` need only be valid in the accept cycle.
- `stack_tos`/`stack_status` are sampled only in the IDLE accept cycle and in READ. They may change freely otherwise.

## Structure

- **Shared include `stack_defs.vh`:**
  - Stack op codes: NONE/PUSH/POP/REPLACE.
  - Stack status codes: NONE/EMPTY/UNDERFLOW/OVERFLOW.
  - Binop opcode constants.
  - `error` codes.
  - The operand stack uses the same file.
- **Sub-module `binop_alu`:** purely combinational `(opcode, a, b) → result, badop`, parameterised by WIDTH. `stack_binop` holds only the FSM and registers.

## Test plan

- **Normal op:** push 7, push 5, request SUB → POP in T+1, REPLACE data=2 in T+3, `done`/`error`=0 in T+4, `tos`=2, stack depth 1.
- **Empty stack:** request ADD on empty stack → `done`=1 with `error`=1 in T+1, `stack_op` stays 0 throughout.
- **Late underflow:** one element (9) on stack, request ADD → POP issued, `done`/`error`=1 in T+3, no REPLACE, `stack_status`=EMPTY.
- **BADOP:** opcode 12 with 2 elements → `done`/`error`=2 in T+1, no stack ops, `tos` unchanged.
- **Opcode sweep, WIDTH=32:**
  - a=0xFFFFFFFF, b=1 → ADD=0, LT_U=0, LT_S=1, SHL=0xFFFFFFFE, SHR_U=0x7FFFFFFF.
  - b=33 → SHL by 1.
  - Back-to-back requests accepted every 4 cycles.
- **Reset mid-operation:** assert `reset` in READ → outputs return to reset values within the same cycle (asynchronous); no `done` pulse; `req_ready`=1 after deassertion; a new ADD completes normally.
